// File: rtl/front_panel_controller.sv
// front_panel_controller
//   Conditions the raw front-panel switches and buttons (2-flop synchroniser
//   plus per-group debouncer) and sequences the CPU clock-advance strobe in
//   manual, auto, halted and programming modes. Also drives the manual RAM
//   programming write port, with optional address auto-increment.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   clk_mode        raw switch: 0 manual stepping, 1 auto clock
//   clk_pulse       raw button: manual step
//   halt            synchronous halt request from control
//   ram_mode        raw switch: 1 programming mode
//   ram_pulse       raw button: write one RAM word
//   auto_inc        raw switch: advance prog_addr after each write
//   addr_switches   raw RAM address switches
//   data_switches   raw RAM data switches
//   cpu_tick        one-cycle CPU half-step enable
//   cpu_clk_led     toggles on every cpu_tick
//   prog_mode       debounced ram_mode
//   prog_we         one-cycle RAM write strobe
//   prog_addr       programming address
//   prog_data       debounced data switches

// Debouncer for one input group: the output takes the input value once the
// two have differed for CYCLES consecutive cycles.
module fpc_debounce #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  always_comb begin
    cnt_d  = '0;
    dout_d = dout_q;
    if (din != dout_q) begin
      if (cnt_q == CNT_LAST) begin
        dout_d = din;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dout_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

module front_panel_controller #(
  parameter int unsigned ADDR_WIDTH      = 4,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned AUTO_DIV        = 13500000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_mode,
  input  logic                  clk_pulse,
  input  logic                  halt,
  input  logic                  ram_mode,
  input  logic                  ram_pulse,
  input  logic                  auto_inc,
  input  logic [ADDR_WIDTH-1:0] addr_switches,
  input  logic [DATA_WIDTH-1:0] data_switches,
  output logic                  cpu_tick,
  output logic                  cpu_clk_led,
  output logic                  prog_mode,
  output logic                  prog_we,
  output logic [ADDR_WIDTH-1:0] prog_addr,
  output logic [DATA_WIDTH-1:0] prog_data
);

  localparam int unsigned SW_W  = ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned RAW_W = 5 + SW_W;
  localparam int unsigned DIV_W = $clog2(AUTO_DIV);
  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(AUTO_DIV - 1);
  localparam logic [DIV_W-1:0]      DIV_ONE  = DIV_W'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_MANUAL,
    ST_AUTO,
    ST_HALTED,
    ST_PROG
  } state_e;

  // ---------------------------------------------------------------- sync
  logic [RAW_W-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {clk_mode, clk_pulse, ram_mode, ram_pulse, auto_inc,
                  addr_switches, data_switches};
      sync2_q <= sync1_q;
    end
  end

  // ------------------------------------------------------------ debounce
  logic            clk_mode_db, clk_pulse_db, ram_mode_db, ram_pulse_db, auto_inc_db;
  logic [SW_W-1:0] sw_db;

  fpc_debounce #(.WIDTH(1), .CYCLES(DEBOUNCE_CYCLES)) u_db_clk_mode (
    .clk(clk), .rst_n(rst_n), .din(sync2_q[RAW_W-1]), .dout(clk_mode_db));
  fpc_debounce #(.WIDTH(1), .CYCLES(DEBOUNCE_CYCLES)) u_db_clk_pulse (
    .clk(clk), .rst_n(rst_n), .din(sync2_q[RAW_W-2]), .dout(clk_pulse_db));
  fpc_debounce #(.WIDTH(1), .CYCLES(DEBOUNCE_CYCLES)) u_db_ram_mode (
    .clk(clk), .rst_n(rst_n), .din(sync2_q[RAW_W-3]), .dout(ram_mode_db));
  fpc_debounce #(.WIDTH(1), .CYCLES(DEBOUNCE_CYCLES)) u_db_ram_pulse (
    .clk(clk), .rst_n(rst_n), .din(sync2_q[RAW_W-4]), .dout(ram_pulse_db));
  fpc_debounce #(.WIDTH(1), .CYCLES(DEBOUNCE_CYCLES)) u_db_auto_inc (
    .clk(clk), .rst_n(rst_n), .din(sync2_q[RAW_W-5]), .dout(auto_inc_db));
  fpc_debounce #(.WIDTH(SW_W), .CYCLES(DEBOUNCE_CYCLES)) u_db_switches (
    .clk(clk), .rst_n(rst_n), .din(sync2_q[SW_W-1:0]), .dout(sw_db));

  logic [ADDR_WIDTH-1:0] addr_db;
  assign addr_db = sw_db[SW_W-1:DATA_WIDTH];

  // ----------------------------------------------------------- sequencer
  state_e                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  tick_q, tick_d;
  logic                  led_q, led_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  clk_pulse_prev_q, ram_pulse_prev_q, auto_inc_prev_q;
  logic [SW_W-1:0]       sw_prev_q;

  logic clk_press, ram_press, stay, prog_entry, sw_changed, auto_inc_rise;

  always_comb begin
    if (ram_mode_db)      state_d = ST_PROG;
    else if (halt)        state_d = ST_HALTED;
    else if (clk_mode_db) state_d = ST_AUTO;
    else                  state_d = ST_MANUAL;

    clk_press     = clk_pulse_db & ~clk_pulse_prev_q;
    ram_press     = ram_pulse_db & ~ram_pulse_prev_q;
    // Strobes are only issued when the mode is not about to change, so a
    // halt or mode switch suppresses output from the very next cycle.
    stay          = (state_d == state_q);
    prog_entry    = (state_d == ST_PROG) && (state_q != ST_PROG);
    sw_changed    = (sw_db != sw_prev_q);
    auto_inc_rise = auto_inc_db & ~auto_inc_prev_q;

    // Divider only runs while remaining in AUTO, so it is zero on every entry.
    div_d  = '0;
    tick_d = 1'b0;
    if ((state_q == ST_AUTO) && stay) begin
      if (div_q == DIV_LAST) begin
        tick_d = 1'b1;
      end else begin
        div_d = div_q + DIV_ONE;
      end
    end
    if ((state_q == ST_MANUAL) && stay && clk_press) begin
      tick_d = 1'b1;
    end
    led_d = led_q ^ tick_d;

    we_d = ram_press && (state_q == ST_PROG) && stay;

    // Reload takes precedence over the post-write increment.
    if (!auto_inc_db || prog_entry || auto_inc_rise || sw_changed) begin
      addr_d = addr_db;
    end else if (we_q) begin
      addr_d = addr_q + ADDR_ONE;
    end else begin
      addr_d = addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_MANUAL;
      div_q            <= '0;
      tick_q           <= 1'b0;
      led_q            <= 1'b0;
      we_q             <= 1'b0;
      addr_q           <= '0;
      clk_pulse_prev_q <= 1'b0;
      ram_pulse_prev_q <= 1'b0;
      auto_inc_prev_q  <= 1'b0;
      sw_prev_q        <= '0;
    end else begin
      state_q          <= state_d;
      div_q            <= div_d;
      tick_q           <= tick_d;
      led_q            <= led_d;
      we_q             <= we_d;
      addr_q           <= addr_d;
      clk_pulse_prev_q <= clk_pulse_db;
      ram_pulse_prev_q <= ram_pulse_db;
      auto_inc_prev_q  <= auto_inc_db;
      sw_prev_q        <= sw_db;
    end
  end

  assign cpu_tick    = tick_q;
  assign cpu_clk_led = led_q;
  assign prog_mode   = ram_mode_db;
  assign prog_we     = we_q;
  assign prog_addr   = addr_q;
  assign prog_data   = sw_db[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_front_panel_controller.sv
module tb_front_panel_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_mode, clk_pulse, halt, ram_mode, ram_pulse, auto_inc;
  logic [3:0] addr_switches;
  logic [7:0] data_switches;
  logic       cpu_tick, cpu_clk_led, prog_mode, prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;

  front_panel_controller #(
    .ADDR_WIDTH(4),
    .DATA_WIDTH(8),
    .DEBOUNCE_CYCLES(4),
    .AUTO_DIV(5)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .clk_mode(clk_mode), .clk_pulse(clk_pulse), .halt(halt),
    .ram_mode(ram_mode), .ram_pulse(ram_pulse), .auto_inc(auto_inc),
    .addr_switches(addr_switches), .data_switches(data_switches),
    .cpu_tick(cpu_tick), .cpu_clk_led(cpu_clk_led), .prog_mode(prog_mode),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Per-window observation record
  int         win_cyc;
  int         n_ticks;
  int         first_tick;
  int         n_we;
  logic [3:0] we_addr[$];
  logic [7:0] we_data[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_win();
    win_cyc    = 0;
    n_ticks    = 0;
    first_tick = -1;
    n_we       = 0;
    we_addr.delete();
    we_data.delete();
  endtask

  // Advance n cycles, sampling outputs on each falling edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (cpu_tick === 1'b1) begin
        if (first_tick < 0) first_tick = win_cyc;
        n_ticks++;
      end
      if (prog_we === 1'b1) begin
        n_we++;
        we_addr.push_back(prog_addr);
        we_data.push_back(prog_data);
      end
      win_cyc++;
    end
  endtask

  function automatic logic [31:0] we_a(input int i);
    return (i < we_addr.size()) ? 32'(we_addr[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] we_d(input int i);
    return (i < we_data.size()) ? 32'(we_data[i]) : 32'hFFFF_FFFF;
  endfunction

  task automatic press_ram();
    ram_pulse = 1'b1; run(8);
    ram_pulse = 1'b0; run(8);
  endtask

  initial begin
    rst_n = 1'b0;
    clk_mode = 1'b0; clk_pulse = 1'b0; halt = 1'b0;
    ram_mode = 1'b0; ram_pulse = 1'b0; auto_inc = 1'b0;
    addr_switches = 4'h0; data_switches = 8'h00;
    clear_win();
    run(3);

    // Reset state
    chk("rst_tick", 32'(cpu_tick), 0);
    chk("rst_led", 32'(cpu_clk_led), 0);
    chk("rst_prog_mode", 32'(prog_mode), 0);
    chk("rst_prog_we", 32'(prog_we), 0);
    chk("rst_prog_addr", 32'(prog_addr), 0);
    chk("rst_prog_data", 32'(prog_data), 0);
    rst_n = 1'b1;
    run(4);

    // Bounce: toggle every 2 cycles for 20 cycles, hold high 10, release 10
    clear_win();
    for (int i = 0; i < 20; i++) begin
      clk_pulse = ((i / 2) % 2 == 0);
      run(1);
    end
    clk_pulse = 1'b1; run(10);
    clk_pulse = 1'b0; run(10);
    chk("bounce_ticks", n_ticks, 1);
    chk("bounce_latency", first_tick, 26);
    chk("bounce_led", 32'(cpu_clk_led), 1);
    chk("bounce_no_we", n_we, 0);

    // Auto: debounce 6, state at 7, ticks at 11, 16, 21
    clear_win();
    clk_mode = 1'b1;
    run(26);
    chk("auto_first", first_tick, 11);
    chk("auto_ticks", n_ticks, 3);
    chk("auto_led", 32'(cpu_clk_led), 0);

    // Halt for 12 cycles, then release: tick 5 cycles after re-entry
    clear_win();
    halt = 1'b1;
    run(12);
    chk("halt_ticks", n_ticks, 0);
    clear_win();
    halt = 1'b0;
    run(8);
    chk("unhalt_first", first_tick, 5);
    chk("unhalt_ticks", n_ticks, 1);
    chk("unhalt_led", 32'(cpu_clk_led), 1);

    // Back to manual
    clk_mode = 1'b0;
    run(10);

    // Programming with address wrap
    clear_win();
    ram_mode = 1'b1; auto_inc = 1'b1;
    addr_switches = 4'hE; data_switches = 8'h3C;
    run(10);
    chk("prog_mode_on", 32'(prog_mode), 1);
    chk("prog_entry_addr", 32'(prog_addr), 32'hE);
    chk("prog_data_3c", 32'(prog_data), 32'h3C);
    press_ram(); press_ram(); press_ram();
    chk("prog_we_count", n_we, 3);
    chk("prog_w0_addr", we_a(0), 32'hE);
    chk("prog_w1_addr", we_a(1), 32'hF);
    chk("prog_w2_addr", we_a(2), 32'h0);
    chk("prog_w0_data", we_d(0), 32'h3C);
    chk("prog_w1_data", we_d(1), 32'h3C);
    chk("prog_w2_data", we_d(2), 32'h3C);
    chk("prog_no_tick", n_ticks, 0);
    chk("prog_addr_after", 32'(prog_addr), 32'h1);

    // Priority: PROG over halt; clk_pulse discarded, ram_pulse still writes
    clear_win();
    halt = 1'b1;
    clk_pulse = 1'b1; run(8);
    clk_pulse = 1'b0; run(8);
    chk("prio_no_tick", n_ticks, 0);
    addr_switches = 4'h5; data_switches = 8'hA5;
    run(8);
    chk("reload_addr", 32'(prog_addr), 32'h5);
    chk("reload_data", 32'(prog_data), 32'hA5);
    clear_win();
    press_ram();
    chk("prio_we_count", n_we, 1);
    chk("prio_we_addr", we_a(0), 32'h5);
    chk("prio_we_data", we_d(0), 32'hA5);
    chk("prio_addr_inc", 32'(prog_addr), 32'h6);
    auto_inc = 1'b0;
    run(8);
    chk("noinc_follow", 32'(prog_addr), 32'h5);

    // Leave PROG; ram_pulse outside PROG is ignored
    halt = 1'b0; ram_mode = 1'b0;
    run(10);
    chk("prog_mode_off", 32'(prog_mode), 0);
    clear_win();
    press_ram();
    chk("manual_no_we", n_we, 0);
    chk("manual_no_tick", n_ticks, 0);

    // Reset mid-operation in AUTO, on a tick cycle
    clear_win();
    clk_mode = 1'b1;
    run(12);
    chk("pre_rst_tick", 32'(cpu_tick), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tick", 32'(cpu_tick), 0);
    chk("mid_rst_led", 32'(cpu_clk_led), 0);
    chk("mid_rst_addr", 32'(prog_addr), 0);
    chk("mid_rst_data", 32'(prog_data), 0);
    chk("mid_rst_we", 32'(prog_we), 0);
    clk_mode = 1'b0;
    run(2);
    rst_n = 1'b1;
    clear_win();
    run(50);
    chk("post_rst_ticks", n_ticks, 0);
    chk("post_rst_led", 32'(cpu_clk_led), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
